aes_inv_rounddata_seq: RTL and testbench

- Sequential AES inverse-cipher datapath with a 32-bit radix. It is the decryption counterpart of the encryption round datapath.
- Takes one 128-bit ciphertext block and runs InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns one column per clock.
- Walks round keys Nr down to 0 and delivers the plaintext block.
- Sits between the key-schedule store, which serves keys by round index, and the top-level core FSM, which uses a start/done handshake.

---
 rtl/aes_inv_pkg.sv | 60 ++++++
 rtl/aes_inv_colword.sv | 27 ++
 rtl/aes_inv_rounddata_seq.sv | 129 ++++++++++++
 tb/tb_aes_inv_rounddata_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_pkg.sv
// rtl/aes_inv_pkg.sv - shared types, constants and GF(2^8) helpers for the inverse round datapath
package aes_inv_pkg;

   localparam logic [1:0] MODE_128 = 2'b00;
   localparam logic [1:0] MODE_192 = 2'b01;
   localparam logic [1:0] MODE_256 = 2'b10;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} inv_state_t;

   // Mode 2'b11 falls into the 14-round case on purpose.
   function automatic logic [3:0] nr_of(input logic [1:0] mode);
      logic [3:0] nr;
      case (mode)
         MODE_128: nr = NR_128;
         MODE_192: nr = NR_192;
         default:  nr = NR_256;
      endcase
      return nr;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] y;
      y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction

endpackage

// File: rtl/aes_inv_colword.sv
// rtl/aes_inv_colword.sv - one column: InvSubBytes, key XOR, InvMixColumns (bypassable)
module aes_inv_colword
   import aes_inv_pkg::*;
(
   input  logic [31:0] col_in,
   input  logic [31:0] key_word,
   input  logic        bypass_mix,
   output logic [31:0] col_out
);

   logic [7:0] b [4];

   // Row 0 sits in the most significant byte of the word.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         b[r] = inv_sbox(col_in[31-8*r -: 8]) ^ key_word[31-8*r -: 8];
      end
      col_out = {b[0], b[1], b[2], b[3]};
      if (!bypass_mix) begin
         for (int r = 0; r < 4; r++) begin
            col_out[31-8*r -: 8] = gf_mul(b[r], 8'h0e) ^ gf_mul(b[(r+1)%4], 8'h0b)
                                 ^ gf_mul(b[(r+2)%4], 8'h0d) ^ gf_mul(b[(r+3)%4], 8'h09);
         end
      end
   end

endmodule

// File: rtl/aes_inv_rounddata_seq.sv
// rtl/aes_inv_rounddata_seq.sv - column-serial AES inverse cipher, round keys walked Nr down to 0
module aes_inv_rounddata_seq
   import aes_inv_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int WORD_W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic [127:0] data_in,
   input  logic [127:0] round_key,
   output logic [3:0]   key_round,
   output logic         busy,
   output logic         done,
   output logic [127:0] data_out
);

   if (DATA_W != 128 || WORD_W != 32) begin : g_param_check
      $error("aes_inv_rounddata_seq supports only DATA_W=128, WORD_W=32");
   end

   inv_state_t   state_q, state_d;
   logic [127:0] st_q, st_d;
   logic [127:0] acc_q, acc_d;
   logic [127:0] data_out_q, data_out_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [1:0]   col_q, col_d;
   logic [127:0] shifted;
   logic [31:0]  w;
   logic [127:0] acc_shift;

   // Word h is the cipher column 3-h, so row r of word h comes from word (h+r)%4.
   for (genvar h = 0; h < 4; h++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign shifted[32*h+31-8*r -: 8] = st_q[32*((h+r)%4)+31-8*r -: 8];
      end
   end

   aes_inv_colword u_colword (
      .col_in     (shifted[{col_q, 5'd0} +: 32]),
      .key_word   (round_key[{col_q, 5'd0} +: 32]),
      .bypass_mix (state_q == FINAL),
      .col_out    (w)
   );

   assign acc_shift = {w, acc_q[127:32]};
   assign data_out  = data_out_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q       <= '0;
         acc_q      <= '0;
         data_out_q <= '0;
         rnd_q      <= '0;
         col_q      <= '0;
      end else begin
         st_q       <= st_d;
         acc_q      <= acc_d;
         data_out_q <= data_out_d;
         rnd_q      <= rnd_d;
         col_q      <= col_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = INIT;
         INIT:    state_d = ROUND;
         ROUND:   if (col_q == 2'd3 && rnd_q == 4'd1) state_d = FINAL;
         FINAL:   if (col_q == 2'd3) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      st_d       = st_q;
      acc_d      = acc_q;
      data_out_d = data_out_q;
      rnd_d      = rnd_q;
      col_d      = col_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               st_d  = data_in;
               rnd_d = nr_of(mode);
               col_d = 2'd0;
            end
         end
         INIT: begin
            st_d  = st_q ^ round_key;
            rnd_d = rnd_q - 4'd1;
            col_d = 2'd0;
         end
         ROUND, FINAL: begin
            acc_d = acc_shift;
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
               st_d = acc_shift;
               if (state_q == ROUND) rnd_d = rnd_q - 4'd1;
               else                  data_out_d = acc_shift;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      key_round = 4'd0;
      case (state_q)
         INIT, ROUND, FINAL: begin
            busy      = 1'b1;
            key_round = rnd_q;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aes_inv_rounddata_seq.sv
// tb/tb_aes_inv_rounddata_seq.sv - scoreboard bench with a byte-array AES reference and key store
module tb_aes_inv_rounddata_seq;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   mode;
   logic [127:0] data_in;
   logic [127:0] round_key;
   logic [3:0]   key_round;
   logic         busy;
   logic         done;
   logic [127:0] data_out;

   aes_inv_rounddata_seq dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .data_in   (data_in),
      .round_key (round_key),
      .key_round (key_round),
      .busy      (busy),
      .done      (done),
      .data_out  (data_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] pt;
      int           cyc;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         mon_e;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           ndone = 0;
   int           n_expected = 0;
   int           last_done = 0;
   int           prev_done = 0;
   logic [7:0]   sbox [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk [16];

   localparam logic [127:0] PT_KNOWN = 128'h00112233445566778899aabbccddeeff;

   always @(posedge clk) cyc <= cyc + 1;
   always_comb round_key = rk[key_round];

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      while (bb != 8'h00) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   // Forward S-box from brute-force inverse plus affine map; inverse table derived from it.
   task automatic init_tables();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
      logic [31:0] wd [60];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = wd[i-1];
         if (i % nk == 0) begin
            t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            t = subword(t);
         end
         wd[i] = wd[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) rk[r] = '0;
      for (int r = 0; r <= nr; r++) rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
   endtask

   // Textbook inverse cipher on a 16-byte state, byte i = column i/4, row i%4.
   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int nr);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] kk, res;
      kk = rk[nr];
      for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ kk[127-8*i -: 8];
      for (int rd = nr - 1; rd >= 0; rd--) begin
         kk = rk[rd];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c-r+4)%4)];
         for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ kk[127-8*i -: 8];
         if (rd > 0) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
               s[4*c+1] = gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d) ^ gm(a0, 8'h09);
               s[4*c+2] = gm(a2, 8'h0e) ^ gm(a3, 8'h0b) ^ gm(a0, 8'h0d) ^ gm(a1, 8'h09);
               s[4*c+3] = gm(a3, 8'h0e) ^ gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09);
            end
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && done) begin
         ndone++;
         prev_done = last_done;
         last_done = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done pulse at cycle %0d with nothing outstanding", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("plaintext", data_out, mon_e.pt);
            chk("done_latency", 128'(cyc), 128'(mon_e.cyc));
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || done) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy=%0b done=%0b required idle", busy, done);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: done=0 required 1");
      end
   endtask

   // Returns at the falling edge inside the INIT cycle.
   task automatic issue(input logic [1:0] m, input logic [255:0] key, input logic [127:0] ct,
                        input logic [127:0] known_pt, input bit use_model);
      int   nr;
      exp_t e;
      nr = (m == 2'b00) ? 10 : (m == 2'b01) ? 12 : 14;
      wait_idle();
      expand_key(key, nr - 6, nr);
      e.pt = use_model ? ref_decrypt(ct, nr) : known_pt;
      mode = m;
      data_in = ct;
      start = 1'b1;
      @(posedge clk);
      #1;
      e.cyc = cyc + 4*nr + 1;
      exp_q.push_back(e);
      n_expected++;
      @(negedge clk);
      start = 1'b0;
      mode = 2'($urandom);
      data_in = {$urandom, $urandom, $urandom, $urandom};
   endtask

   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] rkey;
      logic [127:0] rct;
      logic [3:0]   exp_kr;
      reset = 1'b1;
      start = 1'b0;
      mode = 2'b00;
      data_in = '0;
      for (int i = 0; i < 16; i++) rk[i] = '0;
      init_tables();
      repeat (2) @(negedge clk);
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_done", 128'(done), 128'(0));
      chk("reset_data_out", data_out, 128'(0));
      chk("reset_key_round", 128'(key_round), 128'(0));
      reset = 1'b0;

      issue(2'b00, K128, C128, PT_KNOWN, 1'b0);
      for (int j = 0; j <= 40; j++) begin
         exp_kr = (j == 0) ? 4'd10 : 4'(9 - (j - 1) / 4);
         chk("key_round_walk", 128'(key_round), 128'(exp_kr));
         @(negedge clk);
      end

      issue(2'b01, K192, C192, PT_KNOWN, 1'b0);
      issue(2'b10, K256, C256, PT_KNOWN, 1'b0);
      issue(2'b11, K256, C256, PT_KNOWN, 1'b0);

      issue(2'b00, K128, C128, PT_KNOWN, 1'b0);
      repeat (4) @(negedge clk);
      start = 1'b1;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      start = 1'b0;
      repeat (35) @(negedge clk);
      start = 1'b1;
      mode = 2'($urandom);
      data_in = {$urandom, $urandom, $urandom, $urandom};
      repeat (2) @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);

      issue(2'b10, K256, C256, PT_KNOWN, 1'b0);
      repeat (18) @(negedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("midrun_reset_busy", 128'(busy), 128'(0));
      chk("midrun_reset_done", 128'(done), 128'(0));
      chk("midrun_reset_data_out", data_out, 128'(0));
      chk("midrun_reset_key_round", 128'(key_round), 128'(0));
      void'(exp_q.pop_back());
      n_expected--;
      @(negedge clk);
      reset = 1'b0;
      issue(2'b10, K256, C256, PT_KNOWN, 1'b0);

      wait_done();
      issue(2'b00, K128, C128, PT_KNOWN, 1'b0);
      wait_done();
      issue(2'b00, K128, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h0, 1'b1);
      wait_done();
      @(negedge clk);
      chk("back_to_back_interval", 128'(last_done - prev_done), 128'(43));

      for (int k = 0; k < 10; k++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         rct  = {$urandom, $urandom, $urandom, $urandom};
         issue(2'($urandom_range(0, 3)), rkey, rct, 128'h0, 1'b1);
      end

      wait_idle();
      repeat (20) @(negedge clk);
      chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      chk("done_count", 128'(ndone), 128'(n_expected));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
